// File: rtl/xbar_slave_port_pkg.sv
// Shared crossbar definitions: slave-port state encoding and command values.
package xbar_slave_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/xbar_slave_port_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant,
// priority pointer moves to the loser whenever a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b01):           gnt = 2'b01;
      (req == 2'b10):           gnt = 2'b10;
      (req == 2'b11 && !ptr_q): gnt = 2'b01;
      (req == 2'b11 &&  ptr_q): gnt = 2'b10;
      default:                  gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (upd) begin
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/xbar_slave_port.sv
// Slave-side crossbar port: arbitrates two masters onto one slave,
// with timeout abort and registered ack/err/rdata back to the winner.
module xbar_slave_port
  import xbar_slave_port_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_cmd,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_cmd,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              slave_req,
  output logic [ADDR_W-1:0] slave_addr,
  output logic              slave_cmd,
  output logic [DATA_W-1:0] slave_wdata,
  input  logic              slave_ack,
  input  logic [DATA_W-1:0] slave_rdata
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic [1:0]        sel_mask;
  logic [1:0]        arb_gnt;
  logic              arb_upd;
  logic              req_d, cmd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [1:0]        ack_d, err_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({m1_req, m0_req}),
    .upd   (arb_upd),
    .gnt   (arb_gnt)
  );

  assign sel_mask = {sel_q, ~sel_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    req_d    = slave_req;
    addr_d   = slave_addr;
    cmd_d    = slave_cmd;
    wdata_d  = slave_wdata;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata0_d = m0_rdata;
    rdata1_d = m1_rdata;
    arb_upd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          arb_upd = 1'b1;
          sel_d   = arb_gnt[1];
          addr_d  = arb_gnt[1] ? m1_addr  : m0_addr;
          cmd_d   = arb_gnt[1] ? m1_cmd   : m0_cmd;
          wdata_d = arb_gnt[1] ? m1_wdata : m0_wdata;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (slave_ack) begin
          req_d = 1'b0;
          if (slave_cmd == CMD_WRITE) begin
            ack_d   = sel_mask;
            state_d = RESP;
          end else begin
            state_d = RDWAIT;
          end
        end else if (cnt_q == TO_CNT) begin
          req_d   = 1'b0;
          err_d   = sel_mask;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RDWAIT: begin
        ack_d = sel_mask;
        if (sel_q) rdata1_d = slave_rdata;
        else       rdata0_d = slave_rdata;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      slave_req   <= 1'b0;
      slave_addr  <= '0;
      slave_cmd   <= 1'b0;
      slave_wdata <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      slave_req   <= req_d;
      slave_addr  <= addr_d;
      slave_cmd   <= cmd_d;
      slave_wdata <= wdata_d;
      m0_ack      <= ack_d[0];
      m1_ack      <= ack_d[1];
      m0_err      <= err_d[0];
      m1_err      <= err_d[1];
      m0_rdata    <= rdata0_d;
      m1_rdata    <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_xbar_slave_port.sv
// Scoreboarded bench for xbar_slave_port with a memory-backed slave model.
module tb_xbar_slave_port;
  import xbar_slave_port_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk;
  logic reset;
  logic mreq [2];
  logic mcmd [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwdata [2];
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic slave_req, slave_cmd, slave_ack;
  logic [AW-1:0] slave_addr;
  logic [DW-1:0] slave_wdata, slave_rdata;
  logic [1:0] mack, merr;

  assign mack = {m1_ack, m0_ack};
  assign merr = {m1_err, m0_err};

  xbar_slave_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(mreq[0]), .m0_addr(maddr[0]), .m0_cmd(mcmd[0]),
    .m0_wdata(mwdata[0]), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_rdata(m0_rdata),
    .m1_req(mreq[1]), .m1_addr(maddr[1]), .m1_cmd(mcmd[1]),
    .m1_wdata(mwdata[1]), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_rdata(m1_rdata),
    .slave_req(slave_req), .slave_addr(slave_addr),
    .slave_cmd(slave_cmd), .slave_wdata(slave_wdata),
    .slave_ack(slave_ack), .slave_rdata(slave_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int errors = 0;
  int checks = 0;
  string order_s;
  bit bfm_en = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act,
                       input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // slave model: acks only a changed address, rdata the cycle after ack
  logic [31:0] smem [logic [31:0]];
  logic [31:0] bpa, baddr;
  bit bpv = 0;
  int bdly = 0;
  logic bcmd;

  initial begin
    slave_ack = 1'b0;
    slave_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (slave_ack) begin
        slave_ack = 1'b0;
        if (bcmd == CMD_READ) begin
          if (smem.exists(baddr)) slave_rdata = smem[baddr];
          else slave_rdata = dflt(baddr);
        end else begin
          slave_rdata = $urandom;
        end
      end else begin
        slave_rdata = $urandom;
        if (bfm_en && slave_req && (!bpv || slave_addr != bpa)) begin
          if (bdly == 0) begin
            slave_ack = 1'b1;
            bpa = slave_addr;
            bpv = 1;
            baddr = slave_addr;
            bcmd = slave_cmd;
            if (slave_cmd == CMD_WRITE) smem[slave_addr] = slave_wdata;
            bdly = $urandom_range(0, 3);
          end else begin
            bdly--;
          end
        end
      end
    end
  end

  // reference model + monitor
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rpa;
  bit rpv = 0;
  logic [31:0] exp_rd [2];
  int cyc = 0;
  int rise_cyc = 0;
  bit sack1, sack2, psreq, resp_prev;

  initial begin
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset || !mon_en) begin
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        sack1 = 0;
        sack2 = 0;
        psreq = 0;
        resp_prev = 0;
      end else begin
        if (slave_req && !psreq) rise_cyc = cyc;
        if (resp_prev) chk("req_idle_after_resp", 64'(slave_req), 0);
        resp_prev = 0;
        if (mack != 2'b00 || merr != 2'b00) begin
          int i;
          txn_t t;
          bit eerr;
          bit have;
          i = (mack[1] | merr[1]) ? 1 : 0;
          chk("one_pulse", 64'($countones({mack, merr})), 1);
          chk("req_low_in_resp", 64'(slave_req), 0);
          resp_prev = 1;
          have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp m%0d: got a pulse expected none", i);
          end else begin
            t = (i == 0) ? q0.pop_front() : q1.pop_front();
            eerr = rpv && (t.addr == rpa);
            chk($sformatf("kind_m%0d_%0h", i, t.addr),
                64'({mack[i], merr[i]}), eerr ? 64'b01 : 64'b10);
            if (eerr) begin
              chk("err_latency", 64'(cyc - rise_cyc), 64'(TO + 1));
            end else if (t.cmd == CMD_WRITE) begin
              chk("wr_latency", 64'(sack1), 1);
              ref_mem[t.addr] = t.wdata;
            end else begin
              chk("rd_latency", 64'({sack2, sack1}), 64'b10);
              exp_rd[i] = ref_mem.exists(t.addr) ? ref_mem[t.addr]
                                                 : dflt(t.addr);
            end
            rpa = t.addr;
            rpv = 1;
          end
          chk("m0_rdata", 64'(m0_rdata), 64'(exp_rd[0]));
          chk("m1_rdata", 64'(m1_rdata), 64'(exp_rd[1]));
          order_s = $sformatf("%s%0d", order_s, i);
        end
        sack2 = sack1;
        sack1 = slave_ack;
        psreq = slave_req;
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] a,
                       input logic c, input logic [31:0] d);
    txn_t t;
    bit done;
    t.addr = a;
    t.cmd = c;
    t.wdata = d;
    maddr[i] = a;
    mcmd[i] = c;
    mwdata[i] = d;
    mreq[i] = 1'b1;
    if (i == 0) q0.push_back(t);
    else q1.push_back(t);
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = (i == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout m%0d: got no pulse expected ack or err", i);
    end
    @(posedge clk); #1;
    mreq[i] = 1'b0;
  endtask

  task automatic gap(input int k);
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'({slave_req, slave_cmd, m0_ack, m0_err, m1_ack, m1_err}), 0);
    chk({name, "_addr"}, 64'(slave_addr), 0);
    chk({name, "_wdata"}, 64'(slave_wdata), 0);
    chk({name, "_rdata"}, {m1_rdata, m0_rdata}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int i = 0; i < 2; i++) begin
      mreq[i] = 0;
      mcmd[i] = 0;
      maddr[i] = 0;
      mwdata[i] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    reset = 1'b0;
    mon_en = 1;
    bfm_en = 1;
    gap(1);

    fork
      issue(0, 32'h10, CMD_WRITE, 32'hA5A5_A5A5);
      begin
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          seen = slave_req;
        end
        chk("t1_slave_req", 64'(seen), 1);
        chk("t1_slave_side", {slave_addr, 31'd0, slave_cmd}, {32'h10, 32'd1});
        chk("t1_slave_wdata", 64'(slave_wdata), 64'hA5A5_A5A5);
      end
    join
    issue(1, 32'h14, CMD_READ, 32'h0);

    order_s = "";
    fork
      issue(0, 32'h18, CMD_WRITE, 32'h1111_2222);
      issue(1, 32'h10, CMD_READ, 32'h0);
    join
    fork
      issue(0, 32'h1C, CMD_WRITE, 32'h3333_4444);
      issue(1, 32'h18, CMD_READ, 32'h0);
    join
    issue(0, 32'h24, CMD_WRITE, 32'h5555_6666);
    fork
      issue(0, 32'h28, CMD_WRITE, 32'h7777_8888);
      issue(1, 32'h24, CMD_READ, 32'h0);
    join
    chk_s("rr_order", order_s, "0101010");

    issue(0, 32'h20, CMD_WRITE, 32'h0000_0001);
    issue(0, 32'h20, CMD_WRITE, 32'h0000_0002);
    issue(1, 32'h20, CMD_READ, 32'h0);

    fork
      for (int n = 0; n < 25; n++) begin
        gap($urandom_range(0, 3));
        issue(0, 32'h100 + 32'($urandom_range(0, 3)) * 4,
              1'($urandom_range(0, 1)), $urandom);
      end
      for (int n = 0; n < 25; n++) begin
        gap($urandom_range(0, 3));
        issue(1, 32'h100 + 32'($urandom_range(0, 3)) * 4,
              1'($urandom_range(0, 1)), $urandom);
      end
    join

    gap(2);
    bfm_en = 0;
    maddr[0] = 32'h50;
    mcmd[0] = CMD_WRITE;
    mwdata[0] = 32'hDEAD_0050;
    mreq[0] = 1'b1;
    gap(4);
    chk("busy_before_reset", 64'(slave_req), 1);
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    mreq[0] = 1'b0;
    gap(2);
    reset = 1'b0;
    bfm_en = 1;
    order_s = "";
    fork
      issue(0, 32'h60, CMD_WRITE, 32'h6060_6060);
      issue(1, 32'h10, CMD_READ, 32'h0);
    join
    chk_s("post_reset_order", order_s, "01");

    gap(5);
    chk("q0_drained", 64'(q0.size()), 0);
    chk("q1_drained", 64'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
